// File: rtl/watch_pkg.sv
// Shared constants and types for the watch time-chain digit counters.
package watch_pkg;

    localparam int unsigned DIGIT_W        = 4;
    localparam int unsigned MOD_SEC_UNITS  = 10;
    localparam int unsigned MOD_SEC_TENS   = 6;
    localparam int unsigned MOD_HR_UNITS   = 10;
    localparam int unsigned MOD_HR_TENS    = 3;
    localparam int unsigned HR24_UNITS_LIM = 3;

    // Action selected for the current cycle, in priority order load > tick > hold.
    typedef enum logic [2:0] {
        STEP_HOLD,
        STEP_LOAD,
        STEP_UP,
        STEP_UP_WRAP,
        STEP_DOWN,
        STEP_DOWN_WRAP,
        STEP_DOWN_CLAMP
    } step_e;

endpackage : watch_pkg

// File: rtl/watch_digit_counter_if.sv
// Control and result bundle of one watch digit counter.
interface watch_digit_counter_if #(
    parameter int unsigned WIDTH = 4
);

    logic             tick_i;
    logic             dir_i;
    logic             load_i;
    logic [WIDTH-1:0] ival_i;
    logic [WIDTH-1:0] lim_i;
    logic [WIDTH-1:0] segment_o;
    logic             carry_o;
    logic             borrow_o;
    logic             clkdiv_o;

    modport master (
        output tick_i, dir_i, load_i, ival_i, lim_i,
        input  segment_o, carry_o, borrow_o, clkdiv_o
    );

    modport slave (
        input  tick_i, dir_i, load_i, ival_i, lim_i,
        output segment_o, carry_o, borrow_o, clkdiv_o
    );

endinterface : watch_digit_counter_if

// File: rtl/watch_digit_term.sv
// Terminal value T = min(lim, MODULO-1) and the count-versus-terminal flags.
module watch_digit_term
    import watch_pkg::*;
#(
    parameter int unsigned WIDTH  = DIGIT_W,
    parameter int unsigned MODULO = MOD_SEC_UNITS
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] lim,
    output logic [WIDTH-1:0] term_c,
    output logic             at_term_c,
    output logic             above_term_c,
    output logic             at_zero_c
);

    localparam logic [WIDTH-1:0] MAX_T = WIDTH'(MODULO - 1);

    // at_term_c is ">=" so a count stranded above a lowered limit still wraps on up-ticks.
    always_comb begin
        term_c       = (lim < MAX_T) ? lim : MAX_T;
        at_term_c    = (count >= term_c);
        above_term_c = (count > term_c);
        at_zero_c    = (count == '0);
    end

endmodule : watch_digit_term

// File: rtl/watch_digit_counter.sv
// Modulo-N up/down digit counter with load, runtime limit, carry/borrow and divided clock.
module watch_digit_counter
    import watch_pkg::*;
#(
    parameter int unsigned WIDTH      = DIGIT_W,
    parameter int unsigned MODULO     = MOD_SEC_UNITS,
    parameter int unsigned HALF       = MODULO / 2,
    parameter logic        CLKDIV_RST = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    watch_digit_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] HALF_W  = WIDTH'(HALF);
    localparam logic [WIDTH-1:0] HALF_M1 = WIDTH'(HALF - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             div_q, div_d;

    logic [WIDTH-1:0] term_c;
    logic             at_term_c;
    logic             above_term_c;
    logic             at_zero_c;
    logic             ival_ok_c;
    step_e            step_c;

    watch_digit_term #(
        .WIDTH  (WIDTH),
        .MODULO (MODULO)
    ) u_term (
        .count        (count_q),
        .lim          (bus.lim_i),
        .term_c       (term_c),
        .at_term_c    (at_term_c),
        .above_term_c (above_term_c),
        .at_zero_c    (at_zero_c)
    );

    assign ival_ok_c = (bus.ival_i <= term_c);

    // Decode the cycle's action.
    always_comb begin
        step_c = STEP_HOLD;
        if (bus.load_i) begin
            step_c = STEP_LOAD;
        end else if (bus.tick_i) begin
            if (!bus.dir_i) begin
                step_c = at_term_c ? STEP_UP_WRAP : STEP_UP;
            end else if (at_zero_c) begin
                step_c = STEP_DOWN_WRAP;
            end else if (above_term_c) begin
                step_c = STEP_DOWN_CLAMP;
            end else begin
                step_c = STEP_DOWN;
            end
        end
    end

    // Next-state values; pulses default low so they last exactly one cycle.
    always_comb begin
        count_d  = count_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        div_d    = div_q;
        unique case (step_c)
            STEP_LOAD: begin
                count_d = ival_ok_c ? bus.ival_i : '0;
            end
            STEP_UP: begin
                count_d = count_q + WIDTH'(1);
                if (count_q == HALF_M1) div_d = ~div_q;
            end
            STEP_UP_WRAP: begin
                count_d = '0;
                carry_d = 1'b1;
                div_d   = ~div_q;
            end
            STEP_DOWN: begin
                count_d = count_q - WIDTH'(1);
                if (count_q == HALF_W) div_d = ~div_q;
            end
            STEP_DOWN_WRAP: begin
                count_d  = term_c;
                borrow_d = 1'b1;
                div_d    = ~div_q;
            end
            STEP_DOWN_CLAMP: begin
                count_d = term_c;
                if (count_q == HALF_W) div_d = ~div_q;
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            div_q    <= CLKDIV_RST;
        end else begin
            count_q  <= count_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            div_q    <= div_d;
        end
    end

    assign bus.segment_o = count_q;
    assign bus.carry_o   = carry_q;
    assign bus.borrow_o  = borrow_q;
    assign bus.clkdiv_o  = div_q;

endmodule : watch_digit_counter

// File: tb/tb_watch_digit_counter.sv
// Directed bench for watch_digit_counter with MODULO=10, HALF=5, CLKDIV_RST=1.
module tb_watch_digit_counter;

    logic clk;
    logic rst_ni;
    int   checks;
    int   errors;
    logic exp_div;

    watch_digit_counter_if #(.WIDTH(4)) bus ();

    watch_digit_counter #(
        .WIDTH      (4),
        .MODULO     (10),
        .HALF       (5),
        .CLKDIV_RST (1'b1)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply one cycle of inputs at a falling edge; outputs are settled at the next falling edge.
    task automatic drive(input logic ld, input logic [3:0] iv, input logic tk, input logic dr);
        bus.load_i = ld;
        bus.ival_i = iv;
        bus.tick_i = tk;
        bus.dir_i  = dr;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_ni     = 1'b0;
        bus.load_i = 1'b0;
        bus.ival_i = '0;
        bus.tick_i = 1'b0;
        bus.dir_i  = 1'b0;
        bus.lim_i  = 4'd9;
        #12;
        checks += 4;
        if (bus.segment_o !== 4'd0) begin errors++; $display("FAIL reset_seg: got %0d exp 0", bus.segment_o); end
        if (bus.carry_o !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b exp 0", bus.carry_o); end
        if (bus.borrow_o !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b exp 0", bus.borrow_o); end
        if (bus.clkdiv_o !== 1'b1) begin errors++; $display("FAIL reset_clkdiv: got %b exp 1", bus.clkdiv_o); end
        @(negedge clk);
        rst_ni  = 1'b1;
        exp_div = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_count_up;
        logic [3:0] es;
        logic       ec;
        for (int k = 1; k <= 25; k++) begin
            drive(1'b0, 4'd0, 1'b1, 1'b0);
            es = 4'(k % 10);
            ec = (k % 10 == 0);
            if (k % 5 == 0) exp_div = ~exp_div;
            checks += 3;
            if (bus.segment_o !== es) begin errors++; $display("FAIL up_seg tick %0d: got %0d exp %0d", k, bus.segment_o, es); end
            if (bus.carry_o !== ec) begin errors++; $display("FAIL up_carry tick %0d: got %b exp %b", k, bus.carry_o, ec); end
            if (bus.clkdiv_o !== exp_div) begin errors++; $display("FAIL up_clkdiv tick %0d: got %b exp %b", k, bus.clkdiv_o, exp_div); end
        end
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        checks += 2;
        if (bus.segment_o !== 4'd5) begin errors++; $display("FAIL up_hold_seg: got %0d exp 5", bus.segment_o); end
        if (bus.carry_o !== 1'b0) begin errors++; $display("FAIL up_hold_carry: got %b exp 0", bus.carry_o); end
    endtask

    task automatic test_load_down;
        logic [3:0] exp_seq [3];
        exp_seq[0] = 4'd6; exp_seq[1] = 4'd5; exp_seq[2] = 4'd4;
        drive(1'b1, 4'd7, 1'b0, 1'b0);
        checks += 2;
        if (bus.segment_o !== 4'd7) begin errors++; $display("FAIL load7_seg: got %0d exp 7", bus.segment_o); end
        if (bus.clkdiv_o !== exp_div) begin errors++; $display("FAIL load7_clkdiv: got %b exp %b", bus.clkdiv_o, exp_div); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'd0, 1'b1, 1'b1);
            if (i == 2) exp_div = ~exp_div;
            checks += 3;
            if (bus.segment_o !== exp_seq[i]) begin errors++; $display("FAIL down_seg %0d: got %0d exp %0d", i, bus.segment_o, exp_seq[i]); end
            if (bus.borrow_o !== 1'b0) begin errors++; $display("FAIL down_borrow %0d: got %b exp 0", i, bus.borrow_o); end
            if (bus.clkdiv_o !== exp_div) begin errors++; $display("FAIL down_clkdiv %0d: got %b exp %b", i, bus.clkdiv_o, exp_div); end
        end
        bus.lim_i = 4'd15;
        drive(1'b1, 4'd12, 1'b0, 1'b0);
        checks += 3;
        if (bus.segment_o !== 4'd0) begin errors++; $display("FAIL load12_seg: got %0d exp 0", bus.segment_o); end
        if (bus.carry_o !== 1'b0 || bus.borrow_o !== 1'b0) begin errors++; $display("FAIL load12_pulse: got c%b b%b exp c0 b0", bus.carry_o, bus.borrow_o); end
        if (bus.clkdiv_o !== exp_div) begin errors++; $display("FAIL load12_clkdiv: got %b exp %b", bus.clkdiv_o, exp_div); end
    endtask

    task automatic test_borrow;
        bus.lim_i = 4'd9;
        drive(1'b0, 4'd0, 1'b1, 1'b1);
        exp_div = ~exp_div;
        checks += 3;
        if (bus.segment_o !== 4'd9) begin errors++; $display("FAIL borrow_seg: got %0d exp 9", bus.segment_o); end
        if (bus.borrow_o !== 1'b1) begin errors++; $display("FAIL borrow_pulse: got %b exp 1", bus.borrow_o); end
        if (bus.clkdiv_o !== exp_div) begin errors++; $display("FAIL borrow_clkdiv: got %b exp %b", bus.clkdiv_o, exp_div); end
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        checks += 2;
        if (bus.borrow_o !== 1'b0) begin errors++; $display("FAIL borrow_clear: got %b exp 0", bus.borrow_o); end
        if (bus.segment_o !== 4'd9) begin errors++; $display("FAIL borrow_hold_seg: got %0d exp 9", bus.segment_o); end
    endtask

    task automatic test_limit;
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'd1; exp_seq[1] = 4'd2; exp_seq[2] = 4'd3; exp_seq[3] = 4'd0;
        drive(1'b1, 4'd7, 1'b0, 1'b0);
        bus.lim_i = 4'd3;
        drive(1'b0, 4'd0, 1'b1, 1'b0);
        exp_div = ~exp_div;
        checks += 3;
        if (bus.segment_o !== 4'd0) begin errors++; $display("FAIL lim_wrap_seg: got %0d exp 0", bus.segment_o); end
        if (bus.carry_o !== 1'b1) begin errors++; $display("FAIL lim_wrap_carry: got %b exp 1", bus.carry_o); end
        if (bus.clkdiv_o !== exp_div) begin errors++; $display("FAIL lim_wrap_clkdiv: got %b exp %b", bus.clkdiv_o, exp_div); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'd0, 1'b1, 1'b0);
            if (i == 3) exp_div = ~exp_div;
            checks += 3;
            if (bus.segment_o !== exp_seq[i]) begin errors++; $display("FAIL lim_seg %0d: got %0d exp %0d", i, bus.segment_o, exp_seq[i]); end
            if (bus.carry_o !== (i == 3)) begin errors++; $display("FAIL lim_carry %0d: got %b exp %b", i, bus.carry_o, (i == 3)); end
            if (bus.clkdiv_o !== exp_div) begin errors++; $display("FAIL lim_clkdiv %0d: got %b exp %b", i, bus.clkdiv_o, exp_div); end
        end
        // A count stranded above T clamps to T on a down-tick, without borrow.
        bus.lim_i = 4'd9;
        drive(1'b1, 4'd7, 1'b0, 1'b0);
        bus.lim_i = 4'd3;
        drive(1'b0, 4'd0, 1'b1, 1'b1);
        checks += 3;
        if (bus.segment_o !== 4'd3) begin errors++; $display("FAIL clamp_seg: got %0d exp 3", bus.segment_o); end
        if (bus.borrow_o !== 1'b0) begin errors++; $display("FAIL clamp_borrow: got %b exp 0", bus.borrow_o); end
        if (bus.clkdiv_o !== exp_div) begin errors++; $display("FAIL clamp_clkdiv: got %b exp %b", bus.clkdiv_o, exp_div); end
        bus.lim_i = 4'd9;
    endtask

    task automatic test_load_priority;
        drive(1'b1, 4'd9, 1'b0, 1'b0);
        drive(1'b1, 4'd5, 1'b1, 1'b0);
        checks += 4;
        if (bus.segment_o !== 4'd5) begin errors++; $display("FAIL prio_seg: got %0d exp 5", bus.segment_o); end
        if (bus.carry_o !== 1'b0) begin errors++; $display("FAIL prio_carry: got %b exp 0", bus.carry_o); end
        if (bus.borrow_o !== 1'b0) begin errors++; $display("FAIL prio_borrow: got %b exp 0", bus.borrow_o); end
        if (bus.clkdiv_o !== exp_div) begin errors++; $display("FAIL prio_clkdiv: got %b exp %b", bus.clkdiv_o, exp_div); end
    endtask

    task automatic test_async_reset;
        drive(1'b1, 4'd6, 1'b0, 1'b0);
        bus.load_i = 1'b0;
        checks += 2;
        if (bus.segment_o !== 4'd6) begin errors++; $display("FAIL arst_pre_seg: got %0d exp 6", bus.segment_o); end
        if (bus.clkdiv_o !== exp_div) begin errors++; $display("FAIL arst_pre_clkdiv: got %b exp %b", bus.clkdiv_o, exp_div); end
        #2 rst_ni = 1'b0;
        #1;
        checks += 4;
        if (bus.segment_o !== 4'd0) begin errors++; $display("FAIL arst_seg: got %0d exp 0", bus.segment_o); end
        if (bus.carry_o !== 1'b0) begin errors++; $display("FAIL arst_carry: got %b exp 0", bus.carry_o); end
        if (bus.borrow_o !== 1'b0) begin errors++; $display("FAIL arst_borrow: got %b exp 0", bus.borrow_o); end
        if (bus.clkdiv_o !== 1'b1) begin errors++; $display("FAIL arst_clkdiv: got %b exp 1", bus.clkdiv_o); end
        @(negedge clk);
        rst_ni  = 1'b1;
        exp_div = 1'b1;
        drive(1'b0, 4'd0, 1'b1, 1'b0);
        checks += 1;
        if (bus.segment_o !== 4'd1) begin errors++; $display("FAIL arst_resume_seg: got %0d exp 1", bus.segment_o); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_count_up();
        test_load_down();
        test_borrow();
        test_limit();
        test_load_priority();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_watch_digit_counter
